ct_vfpu_vreg_wkup_gen: RTL and testbench

//  Producer side of the vector-register wakeup protocol for one VFPU pipe (instantiated once each for pipe6 and pipe7).

---
 rtl/ct_vfpu_vreg_wkup_gen_pkg.sv | 30 +++
 rtl/ct_vfpu_vreg_wkup_stage.sv | 34 +++
 rtl/ct_vfpu_vreg_wkup_gen.sv | 143 ++++++++++++++
 tb/tb_ct_vfpu_vreg_wkup_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_vfpu_vreg_wkup_gen_pkg.sv
// Shared definitions for the VFPU vreg wakeup generator.
//   lat_e        : issue latency encoding (3/4/5-cycle pipelined, iterative)
//   stage_ctl_t  : control part of one EX stage record (vreg carried separately
//                  so its width can follow the VREG_W parameter)
//   div_state_e  : iterative-unit sequencer states
package ct_vfpu_vreg_wkup_gen_pkg;

  localparam int VREG_W_DFLT  = 7;
  localparam int DIV_LAT_DFLT = 8;
  localparam int DIV_CNT_W    = 4;

  typedef enum logic [1:0] {
    LAT_3    = 2'd0,
    LAT_4    = 2'd1,
    LAT_5    = 2'd2,
    LAT_ITER = 2'd3
  } lat_e;

  typedef struct packed {
    logic vld;
    logic dst_vld;
    lat_e lat;
  } stage_ctl_t;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/ct_vfpu_vreg_wkup_stage.sv
// One EX stage register of the wakeup tracking pipe.
//   forever_cpuclk : clock
//   cpurst_b       : synchronous active-low reset
//   flush          : kill the op held here (takes effect next cycle)
//   ctl_in/vreg_in : record from the previous stage (or issue)
//   ctl/vreg       : record held in this stage
module ct_vfpu_vreg_wkup_stage
  import ct_vfpu_vreg_wkup_gen_pkg::*;
#(
  parameter int VREG_W = VREG_W_DFLT
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              flush,
  input  stage_ctl_t        ctl_in,
  input  logic [VREG_W-1:0] vreg_in,
  output stage_ctl_t        ctl,
  output logic [VREG_W-1:0] vreg
);

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      ctl  <= '0;
      vreg <= '0;
    end else if (flush) begin
      ctl  <= '0;
      vreg <= '0;
    end else begin
      ctl  <= ctl_in;
      vreg <= vreg_in;
    end
  end

endmodule

// File: rtl/ct_vfpu_vreg_wkup_gen.sv
// Producer side of the vector-register wakeup protocol for one VFPU pipe.
// Tracks pipelined ops through EX1..EX5, sequences one iterative op, and
// drives the early data-ready broadcasts plus the EX5 writeback broadcast.
//   forever_cpuclk / cpurst_b : clock, synchronous active-low reset
//   rtu_yy_xx_flush           : kill every in-flight op
//   x_issue_*                 : op entering RF this cycle (lat 0..2 pipelined, 3 iterative)
//   x_ex1/ex2/ex3_data_vld    : early broadcast for 3/4/5-cycle ops (ex3 also iterative)
//   x_ex5_wb_vreg_vld/_vreg   : result written to vreg file this cycle
//   x_busy                    : iterative unit occupied, issue must be held off
//
// Iterative sequencer
//   state    | meaning
//   DIV_IDLE | div_cnt == 0, no iterative op in flight
//   DIV_RUN  | div_cnt > 0, counting down to writeback
module ct_vfpu_vreg_wkup_gen
  import ct_vfpu_vreg_wkup_gen_pkg::*;
#(
  parameter int VREG_W  = VREG_W_DFLT,
  parameter int DIV_LAT = DIV_LAT_DFLT
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              rtu_yy_xx_flush,
  input  logic              x_issue_vld,
  input  logic              x_issue_dst_vld,
  input  logic [VREG_W-1:0] x_issue_vreg,
  input  logic [1:0]        x_issue_lat,
  output logic              x_ex1_data_vld,
  output logic [VREG_W-1:0] x_ex1_vreg,
  output logic              x_ex2_data_vld,
  output logic [VREG_W-1:0] x_ex2_vreg,
  output logic              x_ex3_data_vld,
  output logic [VREG_W-1:0] x_ex3_vreg,
  output logic              x_ex5_wb_vreg_vld,
  output logic [VREG_W-1:0] x_ex5_wb_vreg,
  output logic              x_busy
);

  localparam logic [DIV_CNT_W-1:0] DIV_LAT_C = DIV_CNT_W'(DIV_LAT);

  logic                 issue_ok;
  logic                 pipe_issue;
  logic                 div_issue;
  stage_ctl_t           issue_ctl;
  stage_ctl_t           st_ctl  [1:5];
  logic [VREG_W-1:0]    st_vreg [1:5];

  div_state_e           div_state;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic                 div_dst;
  logic [VREG_W-1:0]    div_vreg;

  logic                 pipe_ex1;
  logic                 pipe_ex2;
  logic                 pipe_ex3;
  logic                 pipe_wb;
  logic                 div_ex3;
  logic                 div_wb;

  // An issue while busy is a protocol error; the op is simply dropped.
  always_comb begin
    issue_ok          = x_issue_vld & ~x_busy;
    pipe_issue        = issue_ok & (lat_e'(x_issue_lat) != LAT_ITER);
    div_issue         = issue_ok & (lat_e'(x_issue_lat) == LAT_ITER);
    issue_ctl         = '0;
    issue_ctl.vld     = pipe_issue;
    issue_ctl.dst_vld = x_issue_dst_vld;
    issue_ctl.lat     = lat_e'(x_issue_lat);
  end

  for (genvar i = 1; i <= 5; i++) begin : g_stage
    stage_ctl_t        ctl_in;
    logic [VREG_W-1:0] vreg_in;
    if (i == 1) begin : g_head
      assign ctl_in  = issue_ctl;
      assign vreg_in = x_issue_vreg;
    end else begin : g_body
      assign ctl_in  = st_ctl[i-1];
      assign vreg_in = st_vreg[i-1];
    end
    ct_vfpu_vreg_wkup_stage #(.VREG_W(VREG_W)) u_stage (
      .forever_cpuclk (forever_cpuclk),
      .cpurst_b       (cpurst_b),
      .flush          (rtu_yy_xx_flush),
      .ctl_in         (ctl_in),
      .vreg_in        (vreg_in),
      .ctl            (st_ctl[i]),
      .vreg           (st_vreg[i])
    );
  end

  // Reset beats flush, flush beats a new iterative issue.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      div_state <= DIV_IDLE;
      div_cnt   <= '0;
      div_dst   <= 1'b0;
      div_vreg  <= '0;
    end else if (rtu_yy_xx_flush) begin
      div_state <= DIV_IDLE;
      div_cnt   <= '0;
    end else if (div_issue) begin
      div_state <= DIV_RUN;
      div_cnt   <= DIV_LAT_C;
      div_dst   <= x_issue_dst_vld;
      div_vreg  <= x_issue_vreg;
    end else if (div_state == DIV_RUN) begin
      div_cnt <= div_cnt - 1'b1;
      if (div_cnt == 1) begin
        div_state <= DIV_IDLE;
      end
    end
  end

  // Iterative op borrows the ex3 broadcast slot at cnt==3 and the wb slot at
  // cnt==1, i.e. the same 2-cycle spacing a 5-cycle op has.
  always_comb begin
    pipe_ex1 = st_ctl[1].vld & st_ctl[1].dst_vld & (st_ctl[1].lat == LAT_3);
    pipe_ex2 = st_ctl[2].vld & st_ctl[2].dst_vld & (st_ctl[2].lat == LAT_4);
    pipe_ex3 = st_ctl[3].vld & st_ctl[3].dst_vld & (st_ctl[3].lat == LAT_5);
    pipe_wb  = st_ctl[5].vld & st_ctl[5].dst_vld & (st_ctl[5].lat != LAT_ITER);
    div_ex3  = div_dst & (div_cnt == 3);
    div_wb   = div_dst & (div_cnt == 1);
  end

  assign x_ex1_data_vld    = pipe_ex1;
  assign x_ex1_vreg        = pipe_ex1 ? st_vreg[1] : '0;
  assign x_ex2_data_vld    = pipe_ex2;
  assign x_ex2_vreg        = pipe_ex2 ? st_vreg[2] : '0;
  assign x_ex3_data_vld    = pipe_ex3 | div_ex3;
  assign x_ex3_vreg        = ({VREG_W{pipe_ex3}} & st_vreg[3]) | ({VREG_W{div_ex3}} & div_vreg);
  assign x_ex5_wb_vreg_vld = pipe_wb | div_wb;
  assign x_ex5_wb_vreg     = ({VREG_W{pipe_wb}} & st_vreg[5]) | ({VREG_W{div_wb}} & div_vreg);
  assign x_busy            = (div_cnt > 1);

  a_issue_while_busy: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !(x_issue_vld && x_busy));
  a_ex3_exclusive: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !(pipe_ex3 && div_ex3));
  a_wb_exclusive: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !(pipe_wb && div_wb));

endmodule

// File: tb/tb_ct_vfpu_vreg_wkup_gen.sv
module tb_ct_vfpu_vreg_wkup_gen;

  localparam int VW = 7;
  localparam int DL = 8;
  localparam int NC = 2048;

  logic          clk = 1'b0;
  logic          rst_b, flush, iv, dst;
  logic [1:0]    lat;
  logic [VW-1:0] vreg;
  logic          ex1_v, ex2_v, ex3_v, wb_v, busy;
  logic [VW-1:0] ex1_r, ex2_r, ex3_r, wb_r;
  logic [32:0]   dut_out;
  logic [32:0]   obs;

  always #5 clk = ~clk;

  ct_vfpu_vreg_wkup_gen #(.VREG_W(VW), .DIV_LAT(DL)) dut (
    .forever_cpuclk    (clk),
    .cpurst_b          (rst_b),
    .rtu_yy_xx_flush   (flush),
    .x_issue_vld       (iv),
    .x_issue_dst_vld   (dst),
    .x_issue_vreg      (vreg),
    .x_issue_lat       (lat),
    .x_ex1_data_vld    (ex1_v),
    .x_ex1_vreg        (ex1_r),
    .x_ex2_data_vld    (ex2_v),
    .x_ex2_vreg        (ex2_r),
    .x_ex3_data_vld    (ex3_v),
    .x_ex3_vreg        (ex3_r),
    .x_ex5_wb_vreg_vld (wb_v),
    .x_ex5_wb_vreg     (wb_r),
    .x_busy            (busy)
  );

  // {ex1 vld,vreg, ex2 vld,vreg, ex3 vld,vreg, wb vld,vreg, busy}
  assign dut_out = {ex1_v, ex1_r, ex2_v, ex2_r, ex3_v, ex3_r, wb_v, wb_r, busy};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: per-cycle schedule of expected port events, filled in
  // at issue time from the op's latency and cancelled by flush/reset.
  bit          mv1 [NC], mv2 [NC], mv3 [NC], mwb [NC], mbusy [NC];
  bit [VW-1:0] mr1 [NC], mr2 [NC], mr3 [NC], mwr [NC];

  function automatic logic [32:0] model_b(int c);
    return {mv1[c], mr1[c], mv2[c], mr2[c], mv3[c], mr3[c], mwb[c], mwr[c], mbusy[c]};
  endfunction

  task automatic check(string name, logic [32:0] act, logic [32:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_cancel(int c);
    for (int t = c + 1; t <= c + 16; t++) begin
      mv1[t] = 0; mv2[t] = 0; mv3[t] = 0; mwb[t] = 0; mbusy[t] = 0;
      mr1[t] = 0; mr2[t] = 0; mr3[t] = 0; mwr[t] = 0;
    end
  endtask

  task automatic model_issue(logic i_v, logic i_d, logic [1:0] i_l, logic [VW-1:0] i_r,
                             logic i_f, logic i_rb);
    int c = cyc;
    if (!i_rb || i_f) begin
      model_cancel(c);
    end else if (i_v && !mbusy[c]) begin
      if (i_l != 2'd3) begin
        if (i_d) begin
          case (i_l)
            2'd0: begin mv1[c+1] = 1; mr1[c+1] = i_r; end
            2'd1: begin mv2[c+2] = 1; mr2[c+2] = i_r; end
            default: begin mv3[c+3] = 1; mr3[c+3] = i_r; end
          endcase
          mwb[c+5] = 1; mwr[c+5] = i_r;
        end
      end else begin
        for (int k = 1; k <= DL - 1; k++) mbusy[c+k] = 1;
        if (i_d) begin
          mv3[c+DL-2] = 1; mr3[c+DL-2] = i_r;
          mwb[c+DL]   = 1; mwr[c+DL]   = i_r;
        end
      end
    end
  endtask

  // Called at a negedge: observe this cycle's outputs, then drive this
  // cycle's inputs and move to the next negedge.
  task automatic step(logic i_v, logic i_d, logic [1:0] i_l, logic [VW-1:0] i_r,
                      logic i_f, logic i_rb, bit chk);
    obs = dut_out;
    if (chk) check("model", obs, model_b(cyc));
    model_issue(i_v, i_d, i_l, i_r, i_f, i_rb);
    rst_b = i_rb; flush = i_f; iv = i_v; dst = i_d; lat = i_l; vreg = i_r;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  typedef struct {
    logic          iv;
    logic          dst;
    logic [1:0]    lat;
    logic [VW-1:0] vreg;
    logic [32:0]   exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [32:0] eb(int port, logic [VW-1:0] r, logic wv, logic [VW-1:0] wr);
    logic [32:0] b = '0;
    case (port)
      1: begin b[32] = 1'b1; b[31:25] = r; end
      2: begin b[24] = 1'b1; b[23:17] = r; end
      3: begin b[16] = 1'b1; b[15:9]  = r; end
      default: ;
    endcase
    b[8]   = wv;
    b[7:1] = wr;
    return b;
  endfunction

  function automatic vec_t mkv(logic i_v, logic i_d, logic [1:0] i_l, logic [VW-1:0] i_r,
                               int port, logic [VW-1:0] r, logic wv, logic [VW-1:0] wr);
    vec_t v;
    v.iv = i_v; v.dst = i_d; v.lat = i_l; v.vreg = i_r;
    v.exp = eb(port, r, wv, wr);
    return v;
  endfunction

  initial begin
    rst_b = 1'b0; flush = 1'b0; iv = 1'b0; dst = 1'b0; lat = 2'd0; vreg = '0;

    // single lat0 op
    tbl.push_back(mkv(1, 1, 0, 7'h12, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0,     1, 7'h12, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 1, 7'h12));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0, 0));
    // lat0/lat1/lat2 back to back
    tbl.push_back(mkv(1, 1, 0, 7'h01, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 7'h02, 1, 7'h01, 0, 0));
    tbl.push_back(mkv(1, 1, 2, 7'h03, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0,     2, 7'h02, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0,     3, 7'h03, 1, 7'h01));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 1, 7'h02));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 1, 7'h03));
    // ops without a destination
    tbl.push_back(mkv(1, 0, 0, 7'h07, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 2, 7'h08, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0));
    // five in flight, max vreg index
    tbl.push_back(mkv(1, 1, 0, 7'h31, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 7'h32, 1, 7'h31, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 7'h33, 1, 7'h32, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 7'h34, 1, 7'h33, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 7'h7f, 1, 7'h34, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0,     1, 7'h7f, 1, 7'h31));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 1, 7'h32));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 1, 7'h33));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 1, 7'h34));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 1, 7'h7f));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0, 0));

    @(negedge clk);
    step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
    check("reset_state", dut_out, 33'h0);

    foreach (tbl[i]) begin
      check($sformatf("tbl%0d", i), dut_out, tbl[i].exp);
      step(tbl[i].iv, tbl[i].dst, tbl[i].lat, tbl[i].vreg, 1'b0, 1'b1, 1'b1);
    end

    // iterative op behind a lat2 op
    step(1'b1, 1'b1, 2'd2, 7'h05, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 2'd3, 7'h40, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      idle();
      if (k == 2) check("iter_pipe_ex3", obs[16:9], {1'b1, 7'h05});
      if (k == 4) check("iter_pipe_wb",  obs[8:1],  {1'b1, 7'h05});
      if (k == 1) check("iter_busy_first", obs[0], 1'b1);
      if (k == 6) check("iter_ex3", obs[16:0], {1'b1, 7'h40, 8'h00, 1'b1});
      if (k == 7) check("iter_busy_last", obs[16:0], {8'h00, 8'h00, 1'b1});
      if (k == 8) check("iter_wb", obs[16:0], {8'h00, 1'b1, 7'h40, 1'b0});
    end

    // flush with three pipelined ops and the iterative op in flight
    step(1'b1, 1'b1, 2'd0, 7'h11, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 2'd1, 7'h12, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 2'd2, 7'h13, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 2'd3, 7'h44, 1'b0, 1'b1, 1'b1);
    idle();
    step(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 1'b1);
    for (int k = 3; k <= 12; k++) begin
      idle();
      check($sformatf("flush_quiet_t%0d", k), obs, 33'h0);
    end

    // one-cycle reset in the middle of traffic
    step(1'b1, 1'b1, 2'd0, 7'h51, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 2'd2, 7'h52, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 2'd0, 7'h53, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      idle();
      check($sformatf("rst_quiet_t%0d", k), obs, 33'h0);
    end

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int          r;
      logic        r_v, r_d, r_f, r_rb;
      logic [1:0]  r_l;
      logic [VW-1:0] r_r;
      r    = int'($urandom_range(0, 199));
      r_rb = (r < 2) ? 1'b0 : 1'b1;
      r_f  = (r >= 2 && r < 7) ? 1'b1 : 1'b0;
      r_v  = !mbusy[cyc] && ($urandom_range(0, 99) < 60);
      r_l  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_d  = ($urandom_range(0, 9) != 0);
      r_r  = VW'($urandom);
      step(r_v, r_d, r_l, r_r, r_f, r_rb, 1'b1);
    end
    for (int k = 0; k < 12; k++) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
